// File: rtl/tick_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler_if
// Description : Signal bundle between the tick scheduler and its surroundings.
//               It carries the control inputs, the per-core start/ready
//               handshake, the combinational read port into the output spike
//               buffers, the spike event stream toward the router, and the
//               status outputs.
//   master : tick_scheduler side. It drives core_start, rd_*, ev_valid,
//            ev_core, ev_neuron, busy, tick_done and overrun.
//   slave  : environment side. It drives enable, clr_overrun, core_ready,
//            rd_spike and ev_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface tick_scheduler_if #(
  parameter int NUM_CORES   = 4,
  parameter int NUM_NEURONS = 16
);
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int NEUR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                 enable;
  logic                 clr_overrun;
  logic [NUM_CORES-1:0] core_ready;
  logic [NUM_CORES-1:0] core_start;
  logic [CORE_W-1:0]    rd_core;
  logic [NEUR_W-1:0]    rd_neuron;
  logic                 rd_spike;
  logic                 ev_valid;
  logic                 ev_ready;
  logic [CORE_W-1:0]    ev_core;
  logic [NEUR_W-1:0]    ev_neuron;
  logic                 busy;
  logic                 tick_done;
  logic                 overrun;

  modport master (
    input  enable, clr_overrun, core_ready, rd_spike, ev_ready,
    output core_start, rd_core, rd_neuron, ev_valid, ev_core, ev_neuron,
           busy, tick_done, overrun
  );

  modport slave (
    output enable, clr_overrun, core_ready, rd_spike, ev_ready,
    input  core_start, rd_core, rd_neuron, ev_valid, ev_core, ev_neuron,
           busy, tick_done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Global time-step sequencer for the neuron cores. Every
//               TICK_PERIOD cycles it raises a tick request. For each request
//               it pulses start to all cores and waits for every core to be
//               ready. It then scans each core's output spike buffer and sends
//               one event to the router for every neuron that fired.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active low
//   bus   : tick_scheduler_if.master
//           enable/clr_overrun  : tick counter control, overrun clear
//           core_ready/start    : per-core handshake
//           rd_core/neuron/spike: combinational spike-buffer read port
//           ev_*                : valid/ready event stream to the router
//           busy/tick_done/overrun : status
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int NUM_NEURONS = 16,
  parameter int TICK_PERIOD = 1024
) (
  input  wire logic      clk,
  input  wire logic      rst,
  tick_scheduler_if.master bus
);

  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int NEUR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CNT_W  = $clog2(TICK_PERIOD);

  localparam logic [CORE_W-1:0] LAST_CORE   = CORE_W'(NUM_CORES - 1);
  localparam logic [NEUR_W-1:0] LAST_NEURON = NEUR_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TICK_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_GUARD   = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e               state_q,      state_d;
  logic [CNT_W-1:0]     tick_cnt_q,   tick_cnt_d;
  logic                 pending_q,    pending_d;
  logic                 overrun_q,    overrun_d;
  logic [CORE_W-1:0]    rd_core_q,    rd_core_d;
  logic [NEUR_W-1:0]    rd_neuron_q,  rd_neuron_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic                 tick_done_q,  tick_done_d;
  logic                 ev_hold_q,    ev_hold_d;

  logic tick_wrap;
  logic pending_take;
  logic ev_valid_w;

  // --------------------------------------------------------------------------
  // Tick counter
  // --------------------------------------------------------------------------
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_wrap  = 1'b0;
    if (bus.enable) begin
      if (tick_cnt_q == CNT_LAST) begin
        tick_cnt_d = '0;
        tick_wrap  = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
    end else begin
      tick_cnt_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Pending request / sticky overrun
  // A request consumed by IDLE in the same cycle as a new wrap is not an
  // overrun: the new wrap simply re-arms pending.
  // --------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (pending_take) begin
      pending_d = 1'b0;
    end
    if (tick_wrap) begin
      pending_d = 1'b1;
    end
    if (!bus.enable) begin
      pending_d = 1'b0;
    end
    if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
    // A new overrun wins over a clear that arrives in the same cycle.
    if (tick_wrap && pending_q && !pending_take) begin
      overrun_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    rd_core_d    = rd_core_q;
    rd_neuron_d  = rd_neuron_q;
    pending_take = 1'b0;
    ev_valid_w   = 1'b0;
    ev_hold_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          pending_take = 1'b1;
          state_d      = S_START;
        end
      end

      S_START: state_d = S_GUARD;

      // Controllers still show the previous ready for one cycle after start.
      S_GUARD: state_d = S_COMPUTE;

      S_COMPUTE: begin
        if (&bus.core_ready) begin
          state_d     = S_DRAIN;
          rd_core_d   = '0;
          rd_neuron_d = '0;
        end
      end

      S_DRAIN: begin
        // ev_hold_q keeps an offered event valid until it is accepted, even
        // if the read data were to change underneath it.
        ev_valid_w = bus.rd_spike | ev_hold_q;
        if (!ev_valid_w || bus.ev_ready) begin
          if ((rd_core_q == LAST_CORE) && (rd_neuron_q == LAST_NEURON)) begin
            state_d = S_DONE;
          end else if (rd_neuron_q == LAST_NEURON) begin
            rd_neuron_d = '0;
            rd_core_d   = rd_core_q + CORE_W'(1);
          end else begin
            rd_neuron_d = rd_neuron_q + NEUR_W'(1);
          end
        end else begin
          ev_hold_d = 1'b1;
        end
      end

      S_DONE: begin
        rd_core_d   = '0;
        rd_neuron_d = '0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Pulse outputs are registered and follow the state being entered.
    core_start_d = (state_d == S_START) ? {NUM_CORES{1'b1}} : '0;
    tick_done_d  = (state_d == S_DONE);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      rd_core_q    <= '0;
      rd_neuron_q  <= '0;
      core_start_q <= '0;
      tick_done_q  <= 1'b0;
      ev_hold_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      rd_core_q    <= rd_core_d;
      rd_neuron_q  <= rd_neuron_d;
      core_start_q <= core_start_d;
      tick_done_q  <= tick_done_d;
      ev_hold_q    <= ev_hold_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.core_start = core_start_q;
  assign bus.rd_core    = rd_core_q;
  assign bus.rd_neuron  = rd_neuron_q;
  assign bus.ev_valid   = ev_valid_w;
  assign bus.ev_core    = rd_core_q;
  assign bus.ev_neuron  = rd_neuron_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.tick_done  = tick_done_q;
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire
